// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: source-side AXI-Stream bundle plus the MAC-side TX stream.
// slave = scheduler view, master = frame generators and MAC view.
interface eth_tx_sched_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]    src_tvalid;
    logic [NUM_SRC-1:0]    src_tlast;
    logic [NUM_SRC*64-1:0] src_tdata;
    logic [NUM_SRC*8-1:0]  src_tkeep;
    logic [NUM_SRC-1:0]    src_tready;

    logic                  m_axis_tx_tvalid;
    logic                  m_axis_tx_tlast;
    logic                  m_axis_tx_tuser;
    logic [63:0]           m_axis_tx_tdata;
    logic [7:0]            m_axis_tx_tkeep;
    logic                  m_axis_tx_tready;

    modport slave (
        input  src_tvalid,
        input  src_tlast,
        input  src_tdata,
        input  src_tkeep,
        output src_tready,
        output m_axis_tx_tvalid,
        output m_axis_tx_tlast,
        output m_axis_tx_tuser,
        output m_axis_tx_tdata,
        output m_axis_tx_tkeep,
        input  m_axis_tx_tready
    );

    modport master (
        output src_tvalid,
        output src_tlast,
        output src_tdata,
        output src_tkeep,
        input  src_tready,
        input  m_axis_tx_tvalid,
        input  m_axis_tx_tlast,
        input  m_axis_tx_tuser,
        input  m_axis_tx_tdata,
        input  m_axis_tx_tkeep,
        output m_axis_tx_tready
    );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin, frame-atomic scheduler for a shared MAC TX port.
// Define ETH_TX_SCHED_STATS_EN to add per-source frame counters.
module eth_tx_sched #(
    parameter int NUM_SRC = 4,
    parameter int IFG_W   = 28
) (
    input  logic             clk156,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [IFG_W-1:0] ifg_len,
    eth_tx_sched_if.slave    bus,
    output logic [31:0]      frame_cnt,
    output logic             busy
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0] src_frame_cnt
`endif
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    grant_q;
    logic [PW-1:0]    grant_d;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    cand;
    logic             pick_ok;
    int               rr_idx;
    logic [IFG_W-1:0] gap_q;
    logic [IFG_W-1:0] gap_d;
    logic [31:0]      frame_cnt_q;
    logic             frame_inc;
    logic [1:0]       rst_sync;
    logic             run;

    logic [63:0]      s_data [NUM_SRC];
    logic [7:0]       s_keep [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign s_data[g] = bus.src_tdata[g*64 +: 64];
        assign s_keep[g] = bus.src_tkeep[g*8 +: 8];
    end

    // Reset release reaches the FSM only after two clk156 edges.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Round-robin search: first valid source at or after the pointer.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        rr_idx  = 0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_SRC;
            cand   = PW'(rr_idx);
            if (!pick_ok && bus.src_tvalid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    // Next-state, grant hold, gap countdown and output steering.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        frame_inc = 1'b0;

        bus.m_axis_tx_tvalid = 1'b0;
        bus.m_axis_tx_tlast  = 1'b0;
        bus.m_axis_tx_tdata  = '0;
        bus.m_axis_tx_tkeep  = '0;
        bus.src_tready       = '0;

        unique case (state_q)
            IDLE: begin
                if (en && run && pick_ok) begin
                    grant_d = pick;
                    if (int'(pick) == NUM_SRC - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick + PW'(1);
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                bus.m_axis_tx_tvalid = bus.src_tvalid[grant_q];
                bus.m_axis_tx_tlast  = bus.src_tlast[grant_q];
                bus.m_axis_tx_tdata  = s_data[grant_q];
                bus.m_axis_tx_tkeep  = s_keep[grant_q];
                bus.src_tready[grant_q] = bus.m_axis_tx_tready;
                if (bus.src_tvalid[grant_q] &&
                    bus.m_axis_tx_tready &&
                    bus.src_tlast[grant_q]) begin
                    frame_inc = 1'b1;
                    if (ifg_len != '0) begin
                        gap_d   = ifg_len;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q <= IFG_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - IFG_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, grant, pointer, gap and frame counter registers.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            if (frame_inc) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt           = frame_cnt_q;
    assign busy                = (state_q != IDLE);
    assign bus.m_axis_tx_tuser = 1'b0;

`ifdef ETH_TX_SCHED_STATS_EN
    logic [31:0] src_cnt_q [NUM_SRC];

    // Per-source frame counters, bumped alongside frame_cnt.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_cnt_q[i] <= '0;
            end
        end else if (frame_inc) begin
            src_cnt_q[grant_q] <= src_cnt_q[grant_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
        assign src_frame_cnt[g*32 +: 32] = src_cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed stimulus with queued expected beats;
// a negedge monitor pops and compares every accepted MAC beat.
module tb_eth_tx_sched;
    localparam int NS = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  src;
    } beat_t;

    logic          clk156 = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic [27:0]   ifg_len;
    logic [31:0]   frame_cnt;
    logic          busy;
`ifdef ETH_TX_SCHED_STATS_EN
    logic [NS*32-1:0] src_frame_cnt;
`endif

    eth_tx_sched_if #(.NUM_SRC(NS)) bus ();

    eth_tx_sched #(
        .NUM_SRC(NS),
        .IFG_W  (28)
    ) dut (
        .clk156   (clk156),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .ifg_len  (ifg_len),
        .bus      (bus),
        .frame_cnt(frame_cnt),
        .busy     (busy)
`ifdef ETH_TX_SCHED_STATS_EN
        ,
        .src_frame_cnt(src_frame_cnt)
`endif
    );

    always #5 clk156 = ~clk156;

    beat_t         srcq [NS][$];
    beat_t         exp_q [$];
    int            spacing_q [$];
    logic [NS-1:0] stall = '0;
    logic [NS-1:0] hs;
    bit            tog_en = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            beat_cnt = 0;
    int            tlast_cnt = 0;
    beat_t         e;
    logic [NS-1:0] rdy_exp;
    bit            in_frame;
    bit            have_last;
    int            last_cyc;
    logic          quiet_bad;

    always @(posedge clk156) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk156);
        #2;
    endtask

    function automatic beat_t mk_beat(int s, int b, int n, int tag);
        beat_t r;
        logic [7:0]  t8;
        logic [7:0]  s8;
        logic [15:0] b16;
        t8     = tag[7:0];
        s8     = s[7:0];
        b16    = b[15:0];
        r.data = {t8, s8, b16, 16'hC0DE, b16};
        r.last = (b == n - 1);
        r.keep = r.last ? 8'h0F : 8'hFF;
        r.src  = s[1:0];
        return r;
    endfunction

    task automatic add_frame(input int s, input int n, input int tag);
        for (int b = 0; b < n; b++) srcq[s].push_back(mk_beat(s, b, n, tag));
    endtask

    task automatic expect_frame(input int s, input int n, input int tag);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(s, b, n, tag));
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        exp_q.delete();
        spacing_q.delete();
    endtask

    task automatic apply_reset();
        en        = 1'b0;
        sys_rst_n = 1'b0;
        step(2);
        flush();
        stall     = '0;
        sys_rst_n = 1'b1;
        step(3);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            step(1);
            n++;
        end
        chk({nm, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beat_cnt < target && n < 2000) begin
            step(1);
            n++;
        end
        chk("wait_beats", 64'(beat_cnt >= target), 64'd1);
    endtask

    // Source models: present queue heads, pop on observed handshakes.
    initial begin
        bus.src_tvalid = '0;
        bus.src_tlast  = '0;
        bus.src_tdata  = '0;
        bus.src_tkeep  = '0;
        forever begin
            @(negedge clk156);
            hs = bus.src_tvalid & bus.src_tready;
            @(posedge clk156);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0 && !stall[i]) begin
                    bus.src_tvalid[i]        = 1'b1;
                    bus.src_tlast[i]         = srcq[i][0].last;
                    bus.src_tdata[i*64 +: 64] = srcq[i][0].data;
                    bus.src_tkeep[i*8 +: 8]   = srcq[i][0].keep;
                end else begin
                    bus.src_tvalid[i]        = 1'b0;
                    bus.src_tlast[i]         = 1'b0;
                    bus.src_tdata[i*64 +: 64] = '0;
                    bus.src_tkeep[i*8 +: 8]   = '0;
                end
            end
        end
    end

    // MAC backpressure toggler.
    initial begin
        forever begin
            @(posedge clk156);
            #3;
            if (tog_en) bus.m_axis_tx_tready = ~bus.m_axis_tx_tready;
        end
    end

    // Monitor: idle quietness, src_tready routing, beat scoreboard.
    initial begin
        in_frame  = 1'b0;
        have_last = 1'b0;
        last_cyc  = 0;
        forever begin
            @(negedge clk156);
            if (!sys_rst_n) begin
                in_frame  = 1'b0;
                have_last = 1'b0;
            end else begin
                if (!busy) begin
                    quiet_bad = bus.m_axis_tx_tvalid | bus.m_axis_tx_tlast |
                                bus.m_axis_tx_tuser | (|bus.src_tready) |
                                (|bus.m_axis_tx_tdata) |
                                (|bus.m_axis_tx_tkeep);
                    chk("idle_quiet", 64'(quiet_bad), 64'd0);
                end
                if (bus.m_axis_tx_tvalid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none",
                                 bus.m_axis_tx_tdata);
                    end else begin
                        e = exp_q[0];
                        rdy_exp = bus.m_axis_tx_tready ? (NS'(1) << e.src) : '0;
                        chk("src_tready", 64'(bus.src_tready), 64'(rdy_exp));
                        if (bus.m_axis_tx_tready) begin
                            void'(exp_q.pop_front());
                            chk("beat_data", bus.m_axis_tx_tdata, e.data);
                            chk("beat_keep_last_user",
                                64'({bus.m_axis_tx_tkeep, bus.m_axis_tx_tlast,
                                     bus.m_axis_tx_tuser}),
                                64'({e.keep, e.last, 1'b0}));
                            beat_cnt++;
                            if (!in_frame && have_last)
                                spacing_q.push_back(cyc - last_cyc);
                            in_frame = !bus.m_axis_tx_tlast;
                            if (bus.m_axis_tx_tlast) begin
                                last_cyc  = cyc;
                                have_last = 1'b1;
                                tlast_cnt++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int t0;
        sys_rst_n            = 1'b0;
        en                   = 1'b0;
        ifg_len              = '0;
        bus.m_axis_tx_tready = 1'b1;
        apply_reset();

        // reset state
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(bus.m_axis_tx_tvalid), 64'd0);
        chk("rst_src_tready", 64'(bus.src_tready), 64'd0);

        // single source, two back-to-back 8-beat frames, no gap
        add_frame(0, 8, 8'h10);
        add_frame(0, 8, 8'h11);
        expect_frame(0, 8, 8'h10);
        expect_frame(0, 8, 8'h11);
        en = 1'b1;
        drain("single");
        chk("single_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("single_spacing_n", 64'(spacing_q.size()), 64'd1);
        if (spacing_q.size() > 0)
            chk("single_spacing", 64'(spacing_q[0]), 64'd2);

        // all four sources busy: order 0,1,2,3,0
        apply_reset();
        add_frame(0, 3, 8'h20);
        add_frame(0, 2, 8'h24);
        add_frame(1, 4, 8'h21);
        add_frame(2, 2, 8'h22);
        add_frame(3, 5, 8'h23);
        expect_frame(0, 3, 8'h20);
        expect_frame(1, 4, 8'h21);
        expect_frame(2, 2, 8'h22);
        expect_frame(3, 5, 8'h23);
        expect_frame(0, 2, 8'h24);
        step(1);
        en = 1'b1;
        drain("rr");
        chk("rr_frame_cnt", 64'(frame_cnt), 64'd5);
        chk("rr_spacing_n", 64'(spacing_q.size()), 64'd4);
        foreach (spacing_q[i]) chk("rr_spacing", 64'(spacing_q[i]), 64'd2);
`ifdef ETH_TX_SCHED_STATS_EN
        chk("rr_stats", 64'(src_frame_cnt[63:0]), {32'd1, 32'd2});
        chk("rr_stats_hi", 64'(src_frame_cnt[127:64]), {32'd1, 32'd1});
`endif

        // ifg 5 on source 2; ifg change mid-gap is ignored
        spacing_q.delete();
        ifg_len = 28'd5;
        t0 = tlast_cnt;
        add_frame(2, 4, 8'h30);
        add_frame(2, 4, 8'h31);
        expect_frame(2, 4, 8'h30);
        expect_frame(2, 4, 8'h31);
        for (int n = 0; n < 500 && tlast_cnt == t0; n++) step(1);
        ifg_len = 28'd0;
        drain("gap");
        chk("gap_frame_cnt", 64'(frame_cnt), 64'd7);
        chk("gap_spacing_n", 64'(spacing_q.size()), 64'd2);
        if (spacing_q.size() == 2)
            chk("gap_spacing", 64'(spacing_q[1]), 64'd7);

        // toggling MAC ready mid-frame
        tog_en = 1'b1;
        add_frame(0, 6, 8'h40);
        expect_frame(0, 6, 8'h40);
        drain("toggle");
        tog_en = 1'b0;
        bus.m_axis_tx_tready = 1'b1;
        chk("toggle_frame_cnt", 64'(frame_cnt), 64'd8);

        // source valid drops mid-frame: grant held, src3 waits
        b0 = beat_cnt;
        add_frame(1, 6, 8'h50);
        expect_frame(1, 6, 8'h50);
        expect_frame(3, 3, 8'h51);
        wait_beats(b0 + 2);
        stall[1] = 1'b1;
        add_frame(3, 3, 8'h51);
        step(4);
        chk("stall_hold", 64'({busy, bus.m_axis_tx_tvalid}), 64'b10);
        stall[1] = 1'b0;
        drain("stall");
        chk("stall_frame_cnt", 64'(frame_cnt), 64'd10);

        // en dropped at beat 3: frame completes, no new grant
        en = 1'b0;
        add_frame(0, 8, 8'h60);
        add_frame(1, 8, 8'h61);
        expect_frame(0, 8, 8'h60);
        step(1);
        b0 = beat_cnt;
        en = 1'b1;
        wait_beats(b0 + 3);
        en = 1'b0;
        drain("en_drop");
        step(20);
        chk("en_drop_busy", 64'(busy), 64'd0);
        chk("en_drop_pending", 64'(srcq[1].size()), 64'd8);
        chk("en_drop_frame_cnt", 64'(frame_cnt), 64'd11);

        // reset pulse at beat 4 of a frame
        expect_frame(1, 8, 8'h61);
        b0 = beat_cnt;
        en = 1'b1;
        wait_beats(b0 + 4);
        sys_rst_n = 1'b0;
        #1;
        quiet_bad = bus.m_axis_tx_tvalid | (|bus.src_tready) |
                    (|bus.m_axis_tx_tdata) | bus.m_axis_tx_tlast;
        chk("rst_mid_quiet", 64'(quiet_bad), 64'd0);
        chk("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        en = 1'b0;
        step(2);
        flush();
        sys_rst_n = 1'b1;
        step(3);

        // after reset the pointer is back at source 0
        add_frame(2, 2, 8'h70);
        add_frame(0, 3, 8'h71);
        expect_frame(0, 3, 8'h71);
        expect_frame(2, 2, 8'h70);
        step(1);
        en = 1'b1;
        drain("post_rst");
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd2);

        // 3 frames on src1, 2 on src3: order 1,3,1,3,1
        apply_reset();
        add_frame(1, 2, 8'h80);
        add_frame(1, 2, 8'h81);
        add_frame(1, 2, 8'h82);
        add_frame(3, 2, 8'h90);
        add_frame(3, 2, 8'h91);
        expect_frame(1, 2, 8'h80);
        expect_frame(3, 2, 8'h90);
        expect_frame(1, 2, 8'h81);
        expect_frame(3, 2, 8'h91);
        expect_frame(1, 2, 8'h82);
        step(1);
        en = 1'b1;
        drain("stats");
        chk("stats_frame_cnt", 64'(frame_cnt), 64'd5);
`ifdef ETH_TX_SCHED_STATS_EN
        chk("stats_lo", 64'(src_frame_cnt[63:0]), {32'd3, 32'd0});
        chk("stats_hi", 64'(src_frame_cnt[127:64]), {32'd2, 32'd0});
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
